temp_report_tx: RTL
===================

# temp_report_tx

- Sequences the UART transmitter: turns one signed temperature reading into a fixed-format ASCII line and sends it byte by byte.
- Message: sign, three decimal digits, unit character, line ending.
- Sits between the temperature measurement path (valid/ready producer) and the UART transmitter, which consumes `data_byte`/`tx_start` and returns `tx_done_tick`.
- Owns the transmitter exclusively: no other requester drives it.

## Interface
Parameters:
- `UNIT_CHAR`, default 8'h43 ('C'): ASCII unit byte sent after the digits.
- `EOL_CRLF`, default 1: 1 sends CR LF (7-byte message); 0 sends LF only (6-byte message).

Ports:
- `clk`  in  1  clock; reset is `reset`, asynchronous, active-high.
- `reset`  in  1  asynchronous, active-high reset.
- `temp`  in  8  signed two's-complement temperature, integer °C, -128..127.
- `temp_valid`  in  1  producer has a reading.
- `temp_ready`  out  1  high only in IDLE; a reading is accepted on a rising edge with `temp_valid && temp_ready`.
- `data_byte`  out  8  byte presented to the transmitter.
- `tx_start`  out  1  active-low start request to the transmitter; low for exactly one cycle per byte.
- `tx_done_tick`  in  1  one-cycle pulse from the transmitter at the end of each stop bit.
- `busy`  out  1  high in any state other than IDLE.
- `msg_done`  out  1  one-cycle pulse after the last byte's `tx_done_tick`.

## Operation
States: IDLE, CONVERT, LOAD, WAIT.

IDLE
- `temp_ready` = 1.
- On accept: latch sign = `temp[7]`; magnitude = |temp| as 8-bit unsigned (-128 gives 128).
- Start the converter and go to CONVERT.

CONVERT
- Double-dabble binary-to-BCD over 8 magnitude bits. Result: hundreds (0–1), tens, units.
- Go to LOAD when the converter asserts done; byte index = 0.

LOAD
- Drive `data_byte` = message[index] and `tx_start` = 0 for this one cycle.
- Go to WAIT.

WAIT
- Keep `tx_start` = 1 and hold `data_byte` stable.
- On `tx_done_tick`:
  - If index == MSG_LEN-1: go to IDLE and pulse `msg_done`.
  - Otherwise: index+1, go to LOAD.

Message bytes, in order:
- byte 0: '+' (8'h2B) if sign = 0, '-' (8'h2D) if sign = 1.
- bytes 1–3: 8'h30 + hundreds, 8'h30 + tens, 8'h30 + units. Leading zeros are always sent.
- byte 4: `UNIT_CHAR`.
- bytes 5–6: 8'h0D then 8'h0A. With `EOL_CRLF` = 0, byte 5 is 8'h0A and the message ends there.

Boundary and error cases:
- `temp_valid` while busy: ignored. No queueing; the producer must hold valid until ready.
- `tx_done_tick` outside WAIT: ignored.
- Reset mid-message: every state returns to reset values immediately and the partial message is abandoned. A `tx_done_tick` arriving after reset in IDLE is ignored.
- Index counter width is 3 bits. It never exceeds MSG_LEN-1 (6 or 5).

## Timing
Reset values:
- state IDLE; `tx_start` 1; `data_byte` 8'h00.
- `busy` 0; `msg_done` 0; `temp_ready` 1 (combinational from state).

Latency and handshake:
- Accept edge at cycle 0. CONVERT occupies cycles 1–9: converter start plus 8 shift iterations, fixed for every value. LOAD is cycle 10, so the first `tx_start` low is 10 cycles after accept.
- Between bytes, LOAD follows the `tx_done_tick` cycle by exactly one cycle.
- `msg_done` is asserted in the cycle after the final `tx_done_tick`, coincident with return to IDLE. `temp_ready` rises in that same cycle.
- `data_byte` changes only on entry to LOAD, and is valid in the cycle `tx_start` is low.
- All outputs except `temp_ready` are registered.

## Structure
- Package `temp_report_pkg` holds:
  - the state enum (IDLE, CONVERT, LOAD, WAIT);
  - ASCII constants: plus, minus, zero base, CR, LF;
  - MSG_LEN as a function of `EOL_CRLF`.
- Sub-module `bin2bcd_seq`.
  - Ports: `clk`, `reset`, `start`, 8-bit `bin`, `done` (one-cycle pulse), 4-bit `hundreds`, `tens`, `units`.
  - Fixed 8-iteration double-dabble.
  - Reusable by the display path.

## Test plan
- `temp` = +23 (8'h17) → bytes 2B 30 32 33 43 0D 0A. `msg_done` pulses once. First `tx_start` low exactly 10 cycles after accept.
- `temp` = -128 (8'h80) → 2D 31 32 38 43 0D 0A. `temp` = 0 → 2B 30 30 30 43 0D 0A.
- `EOL_CRLF` = 0, `temp` = -5 (8'hFB) → 2D 30 30 35 43 0A. 6 start pulses, then `msg_done`.
- `temp_valid` pulsed repeatedly during a message with differing values → only the first reading is transmitted. Next reading is accepted in the `msg_done` cycle. Stray `tx_done_tick` in IDLE/CONVERT → no index change.
- `reset` asserted mid-WAIT on byte 3 → `tx_start` 1, `busy` 0, `data_byte` 00 immediately. A following `tx_done_tick` is ignored. The next reading produces a full 7-byte message from byte 0.
- Transmitter model with a random 0–40 cycle done latency over 200 random temps → every byte matches the decimal reference. `tx_start` is never low outside LOAD and never low on two consecutive cycles.

Source files
------------

// File: rtl/temp_report_pkg.sv
// temp_report_pkg: shared FSM states, ASCII constants and message length for the temperature report path
package temp_report_pkg;
   typedef enum logic [1:0] {IDLE, CONVERT, LOAD, WAIT} state_e;
   localparam logic [7:0] ASCII_PLUS  = 8'h2B;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   function automatic logic [2:0] msg_len(input bit eol_crlf);
      return eol_crlf ? 3'd7 : 3'd6;
   endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: fixed 8-iteration sequential double-dabble, 8-bit binary to three BCD digits
module bin2bcd_seq (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] bin,
   output logic       done,
   output logic [3:0] hundreds,
   output logic [3:0] tens,
   output logic [3:0] units
);
   logic [19:0] sh_q, sh_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        run_q, run_d, done_q, done_d;
   function automatic logic [19:0] dabble(input logic [19:0] x);
      logic [19:0] y;
      y = x;
      for (int i = 8; i < 20; i += 4)
         if (y[i +: 4] > 4'd4) y[i +: 4] = y[i +: 4] + 4'd3;
      return {y[18:0], 1'b0};
   endfunction
   // The start cycle performs the first iteration, so done lands after exactly 8 shifts.
   always_comb begin
      sh_d   = start ? dabble({12'd0, bin}) : run_q ? dabble(sh_q) : sh_q;
      cnt_d  = start ? 3'd1 : run_q ? cnt_q + 3'd1 : cnt_q;
      run_d  = start || (run_q && cnt_q != 3'd7);
      done_d = !start && run_q && cnt_q == 3'd7;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_q   <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         sh_q   <= sh_d;
         cnt_q  <= cnt_d;
         run_q  <= run_d;
         done_q <= done_d;
      end
   end
   assign done     = done_q;
   assign hundreds = sh_q[19:16];
   assign tens     = sh_q[15:12];
   assign units    = sh_q[11:8];
endmodule

// File: rtl/temp_report_tx.sv
// temp_report_tx: formats one signed temperature reading as an ASCII line and feeds it to the UART transmitter
module temp_report_tx
   import temp_report_pkg::*;
#(
   parameter logic [7:0] UNIT_CHAR = 8'h43,
   parameter bit         EOL_CRLF  = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] temp,
   input  logic       temp_valid,
   output logic       temp_ready,
   output logic [7:0] data_byte,
   output logic       tx_start,
   input  logic       tx_done_tick,
   output logic       busy,
   output logic       msg_done
);
   localparam logic [2:0] LAST_IDX = msg_len(EOL_CRLF) - 3'd1;
   state_e          state_q, state_d;
   logic            sign_q, sign_d;
   logic [7:0]      mag_q, mag_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      data_byte_q, data_byte_d;
   logic            conv_start_q, conv_start_d;
   logic            tx_start_q, tx_start_d;
   logic            busy_q, busy_d;
   logic            msg_done_q, msg_done_d;
   logic            conv_done;
   logic [3:0]      hundreds, tens, units;
   logic [7:0][7:0] msg;
   bin2bcd_seq u_bcd (
      .clk      (clk),
      .reset    (reset),
      .start    (conv_start_q),
      .bin      (mag_q),
      .done     (conv_done),
      .hundreds (hundreds),
      .tens     (tens),
      .units    (units)
   );
   // msg[i] is the byte sent at index i; slot 7 is never reached.
   assign msg = {8'h00, ASCII_LF, EOL_CRLF ? ASCII_CR : ASCII_LF, UNIT_CHAR,
                 ASCII_ZERO + {4'd0, units}, ASCII_ZERO + {4'd0, tens},
                 ASCII_ZERO + {4'd0, hundreds}, sign_q ? ASCII_MINUS : ASCII_PLUS};
   always_comb begin
      state_d      = state_q;
      sign_d       = sign_q;
      mag_d        = mag_q;
      idx_d        = idx_q;
      data_byte_d  = data_byte_q;
      conv_start_d = 1'b0;
      tx_start_d   = 1'b1;
      msg_done_d   = 1'b0;
      case (state_q)
         IDLE: if (temp_valid) begin
            sign_d       = temp[7];
            mag_d        = temp[7] ? 8'd0 - temp : temp;
            conv_start_d = 1'b1;
            state_d      = CONVERT;
         end
         CONVERT: if (conv_done) begin
            idx_d       = 3'd0;
            data_byte_d = msg[0];
            tx_start_d  = 1'b0;
            state_d     = LOAD;
         end
         LOAD: state_d = WAIT;
         WAIT: if (tx_done_tick) begin
            if (idx_q == LAST_IDX) begin
               msg_done_d = 1'b1;
               state_d    = IDLE;
            end else begin
               idx_d       = idx_q + 3'd1;
               data_byte_d = msg[idx_q + 3'd1];
               tx_start_d  = 1'b0;
               state_d     = LOAD;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         sign_q       <= 1'b0;
         mag_q        <= '0;
         idx_q        <= '0;
         data_byte_q  <= '0;
         conv_start_q <= 1'b0;
         tx_start_q   <= 1'b1;
         busy_q       <= 1'b0;
         msg_done_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         sign_q       <= sign_d;
         mag_q        <= mag_d;
         idx_q        <= idx_d;
         data_byte_q  <= data_byte_d;
         conv_start_q <= conv_start_d;
         tx_start_q   <= tx_start_d;
         busy_q       <= busy_d;
         msg_done_q   <= msg_done_d;
      end
   end
   assign temp_ready = state_q == IDLE;
   assign data_byte  = data_byte_q;
   assign tx_start   = tx_start_q;
   assign busy       = busy_q;
   assign msg_done   = msg_done_q;
endmodule
